// File: rtl/uart_cmd_wrapper.sv
// Remote command link endpoint: 3-byte command frames in over UART,
// 1-byte responses out, with partial-frame timeout.
module uart_cmd_wrapper #(
  parameter int TMO_CYCLES = 1_000_000,
  parameter int BAUD_DIV   = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int TW = $clog2(TMO_CYCLES);
  localparam int BW = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

  logic          rx_s1, rx_s2;
  logic          rx_busy;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [9:0]    rx_sr;
  logic          rx_rdy;
  logic          clr_rx_rdy;
  logic [7:0]    rx_data;

  logic          trmt;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          tx_act;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_sr;

  logic          busy;
  logic          accept;

  rx_state_t     state, nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [7:0]    sh_cmd;
  logic [7:0]    sh_hi;

  assign rx_data    = rx_sr[8:1];
  assign clr_rx_rdy = rx_rdy;
  assign TX         = tx_sr[0];
  assign accept     = send_resp && !busy;

  // Receiver: ten mid-bit samples (start, 8 data, stop)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_busy <= 1'b0;
      rx_baud <= '0;
      rx_bits <= '0;
      rx_sr   <= '1;
      rx_rdy  <= 1'b0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      if (clr_rx_rdy)
        rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s2) begin
          rx_busy <= 1'b1;
          rx_baud <= BW'(BAUD_DIV / 2);
          rx_bits <= '0;
        end
      end else if (rx_baud == '0) begin
        rx_sr   <= {rx_s2, rx_sr[9:1]};
        rx_baud <= BW'(BAUD_DIV - 1);
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end
      end else begin
        rx_baud <= rx_baud - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_act  <= 1'b0;
      tx_baud <= '0;
      tx_bits <= '0;
      tx_sr   <= '1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (trmt) begin
        tx_sr   <= {1'b1, tx_data, 1'b0};
        tx_act  <= 1'b1;
        tx_baud <= BW'(BAUD_DIV - 1);
        tx_bits <= '0;
      end else if (tx_act) begin
        if (tx_baud == '0) begin
          tx_sr   <= {1'b1, tx_sr[9:1]};
          tx_baud <= BW'(BAUD_DIV - 1);
          tx_bits <= tx_bits + 4'd1;
          if (tx_bits == 4'd9) begin
            tx_act  <= 1'b0;
            tx_done <= 1'b1;
          end
        end else begin
          tx_baud <= tx_baud - BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt      <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      trmt <= accept;
      if (accept) begin
        tx_data   <= resp;
        busy      <= 1'b1;
        resp_sent <= 1'b0;
      end else if (tx_done) begin
        busy      <= 1'b0;
        resp_sent <= 1'b1;
      end
    end
  end

  // A byte arriving on the timeout cycle suppresses the timeout
  assign tmo_hit = (state != IDLE) && !rx_rdy &&
                   (tmo_cnt == TW'(TMO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (rx_rdy) nxt = HIGH;
      HIGH: begin
        if (rx_rdy)       nxt = LOW;
        else if (tmo_hit) nxt = IDLE;
      end
      LOW:  if (rx_rdy || tmo_hit) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      frm_err <= 1'b0;
      sh_cmd  <= '0;
      sh_hi   <= '0;
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
    end else begin
      frm_err <= tmo_hit;
      if (state == IDLE || rx_rdy || tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);
      if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;
      if (tmo_hit) begin
        sh_cmd <= '0;
        sh_hi  <= '0;
      end
      if (rx_rdy) begin
        unique case (state)
          IDLE: sh_cmd <= rx_data;
          HIGH: sh_hi  <= rx_data;
          LOW: begin
            cmd     <= sh_cmd;
            data    <= {sh_hi, rx_data};
            cmd_rdy <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: bit-level far-end UART driver/monitor,
// frame-level reference model, table vectors plus random frames.
module tb_uart_cmd_wrapper;

  localparam int TMO = 5000;
  localparam int BD  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        frm_err;

  uart_cmd_wrapper #(
    .TMO_CYCLES(TMO),
    .BAUD_DIV(BD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .RX(RX),
    .TX(TX),
    .cmd(cmd),
    .data(data),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp(resp),
    .send_resp(send_resp),
    .resp_sent(resp_sent),
    .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx[$];

  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_rdy = 1'b0;
  logic [7:0]  part[$];
  int          m_err = 0;

  typedef struct {
    int          n;
    logic [23:0] bytes;
    bit          long_w;
    bit          clr;
    logic [7:0]  e_cmd;
    logic [15:0] e_data;
    logic        e_rdy;
    int          e_err;
  } vec_t;

  vec_t tbl[5];

  always @(posedge clk)
    if (rst_n && frm_err === 1'b1) err_cnt++;

  // Far-end receiver: decodes bytes from TX
  initial begin
    logic [7:0] b;
    wait (rst_n);
    forever begin
      @(posedge clk);
      if (rst_n && TX === 1'b0) begin
        repeat (BD / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(posedge clk);
          b[i] = TX;
        end
        repeat (BD) @(posedge clk);
        tx_q.push_back(b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  // Model: every third consecutive byte completes a frame
  task automatic model_byte(input logic [7:0] b);
    part.push_back(b);
    if (part.size() == 3) begin
      m_cmd  = part[0];
      m_data = {part[1], part[2]};
      m_rdy  = 1'b1;
      part.delete();
    end
  endtask

  task automatic send_frame(input int n, input logic [23:0] bytes,
                            input bit long_w);
    for (int k = 0; k < n; k++) begin
      send_byte(bytes[23-8*k -: 8]);
      model_byte(bytes[23-8*k -: 8]);
      if (k < n - 1) repeat ($urandom_range(0, 200)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    if (long_w) begin
      repeat (TMO + 200) @(negedge clk);
      if (part.size() != 0) begin
        part.delete();
        m_err++;
      end
    end
  endtask

  task automatic clr_pulse(input string nm);
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    chk(nm, cmd_rdy, m_rdy);
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".cmd"}, cmd, m_cmd);
    chk({tag, ".data"}, data, m_data);
    chk({tag, ".rdy"}, cmd_rdy, m_rdy);
    chk({tag, ".err"}, err_cnt, m_err);
  endtask

  task automatic send_rsp(input logic [7:0] b);
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    exp_tx.push_back(b);
  endtask

  task automatic wait_sent(input string nm);
    int t;
    t = 0;
    while (resp_sent !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, resp_sent, 1'b1);
  endtask

  initial begin
    int hit;
    tbl[0] = '{3, 24'h021234, 1'b0, 1'b1, 8'h02, 16'h1234, 1'b1, 0};
    tbl[1] = '{3, 24'h05ABCD, 1'b0, 1'b0, 8'h05, 16'hABCD, 1'b1, 0};
    tbl[2] = '{3, 24'h060001, 1'b0, 1'b1, 8'h06, 16'h0001, 1'b1, 0};
    tbl[3] = '{2, 24'h075500, 1'b1, 1'b0, 8'h06, 16'h0001, 1'b0, 1};
    tbl[4] = '{3, 24'h0800FF, 1'b0, 1'b1, 8'h08, 16'h00FF, 1'b1, 1};

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.cmd", cmd, 8'h00);
    chk("rst.data", data, 16'h0000);
    chk("rst.rdy", cmd_rdy, 1'b0);
    chk("rst.sent", resp_sent, 1'b0);
    chk("rst.err", frm_err, 1'b0);
    chk("rst.tx", TX, 1'b1);

    foreach (tbl[i]) begin
      send_frame(tbl[i].n, tbl[i].bytes, tbl[i].long_w);
      chk($sformatf("v%0d.cmd", i), cmd, tbl[i].e_cmd);
      chk($sformatf("v%0d.data", i), data, tbl[i].e_data);
      chk($sformatf("v%0d.rdy", i), cmd_rdy, tbl[i].e_rdy);
      chk($sformatf("v%0d.err", i), err_cnt, tbl[i].e_err);
      if (tbl[i].clr) clr_pulse($sformatf("v%0d.clr", i));
    end

    // clear coinciding with frame completion: set must win
    send_byte(8'h0B); model_byte(8'h0B);
    send_byte(8'h01); model_byte(8'h01);
    hit = 0;
    fork
      send_byte(8'h02);
      begin
        int t;
        t = 0;
        while (dut.rx_rdy !== 1'b1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        if (t < 400) begin
          hit = 1;
          clr_cmd_rdy = 1'b1;
          @(negedge clk);
          clr_cmd_rdy = 1'b0;
        end
      end
    join
    model_byte(8'h02);
    chk("same.hit", hit, 1);
    repeat (20) @(negedge clk);
    check_out("same");

    // response: second request while busy must be dropped
    send_rsp(8'hA5);
    chk("rsp.clr", resp_sent, 1'b0);
    repeat (3) @(negedge clk);
    resp = 8'h3C;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    wait_sent("rsp.a5");
    send_rsp(8'hFF);
    chk("rsp.clr2", resp_sent, 1'b0);
    wait_sent("rsp.ff");
    repeat (40) @(negedge clk);
    chk("rsp.count", tx_q.size(), 2);

    // reset in the middle of a frame
    send_byte(8'h09);
    send_byte(8'h77);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst.cmd", cmd, 8'h00);
    chk("mrst.data", data, 16'h0000);
    chk("mrst.rdy", cmd_rdy, 1'b0);
    chk("mrst.sent", resp_sent, 1'b0);
    chk("mrst.tx", TX, 1'b1);
    rst_n = 1'b1;
    m_cmd = 8'h00;
    m_data = 16'h0000;
    m_rdy = 1'b0;
    part.delete();
    send_frame(3, 24'h0ABEEF, 1'b0);
    check_out("mrst.frame");
    chk("mrst.cmd0a", cmd, 8'h0A);

    for (int i = 0; i < 10; i++) begin
      int          n;
      logic [23:0] bytes;
      n = (i % 4 == 3) ? 2 : 3;
      bytes = 24'($urandom);
      if ($urandom_range(0, 1) == 1) send_rsp(8'($urandom));
      send_frame(n, bytes, n == 2);
      check_out($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) clr_pulse($sformatf("rnd%0d.clr", i));
    end

    repeat (400) @(negedge clk);
    chk("tx.count", tx_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      chk($sformatf("tx.byte%0d", i), tx_q[i], exp_tx[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
